// File: rtl/vga_scan_driver.sv
// VGA raster generator: issues pixel requests to the raytracer, realigns the
// returned colour with delayed sync, then quantises to 2 bits/channel with optional dither.
module vga_scan_driver #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RT_LATENCY = 1,
    parameter int DITHER     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_valid,
    output logic       frame_start,
    input  logic [7:0] rgb_r,
    input  logic [7:0] rgb_g,
    input  logic [7:0] rgb_b,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic vld;
        logic hs;
        logic vs;
        logic x0;
        logic y0;
    } align_t;

    localparam align_t ALIGN_RST = '{vld: 1'b0, hs: 1'b1, vs: 1'b1, x0: 1'b0, y0: 1'b0};

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_last)
                r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end
    end

    // Stage 0: request registers and raw (undelayed) sync levels.
    logic [9:0] r_px;
    logic [9:0] r_py;
    logic       r_pv;
    logic       r_fs;
    logic       r_hs;
    logic       r_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px <= '0;
            r_py <= '0;
            r_pv <= 1'b0;
            r_fs <= 1'b0;
            r_hs <= 1'b1;
            r_vs <= 1'b1;
        end else begin
            r_px <= r_h_cnt;
            r_py <= r_v_cnt;
            r_pv <= (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
            r_fs <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
            r_hs <= !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
            r_vs <= !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
        end
    end

    assign pixel_x     = r_px;
    assign pixel_y     = r_py;
    assign pixel_valid = r_pv;
    assign frame_start = r_fs;

    align_t w_stg0;
    align_t w_stgl;

    assign w_stg0 = '{vld: r_pv, hs: r_hs, vs: r_vs, x0: r_px[0], y0: r_py[0]};

    // Delay line matching the raytracer latency so stage L lines up with rgb_*.
    generate
        if (RT_LATENCY == 0) begin : g_nopipe
            assign w_stgl = w_stg0;
        end else begin : g_pipe
            align_t [RT_LATENCY-1:0] r_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RT_LATENCY; i++)
                        r_pipe[i] <= ALIGN_RST;
                end else begin
                    r_pipe[0] <= w_stg0;
                    for (int i = 1; i < RT_LATENCY; i++)
                        r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_stgl = r_pipe[RT_LATENCY-1];
        end
    endgenerate

    function automatic logic [1:0] quant(input logic [7:0] c, input logic [5:0] d);
        logic [8:0] s;
        s = {1'b0, c} + {3'b000, d};
        return s[8] ? 2'd3 : s[7:6];
    endfunction

    logic [5:0] w_dith;

    always_comb begin
        w_dith = 6'd0;
        if (DITHER != 0) begin
            case ({w_stgl.y0, w_stgl.x0})
                2'b00:   w_dith = 6'd0;
                2'b01:   w_dith = 6'd32;
                2'b10:   w_dith = 6'd48;
                default: w_dith = 6'd16;
            endcase
        end
    end

    logic [1:0] w_qr;
    logic [1:0] w_qg;
    logic [1:0] w_qb;

    assign w_qr = quant(rgb_r, w_dith);
    assign w_qg = quant(rgb_g, w_dith);
    assign w_qb = quant(rgb_b, w_dith);

    logic [1:0] r_vga_r;
    logic [1:0] r_vga_g;
    logic [1:0] r_vga_b;
    logic       r_vga_hs;
    logic       r_vga_vs;

    // Blanking is forced black regardless of what the core returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
            r_vga_hs <= 1'b1;
            r_vga_vs <= 1'b1;
        end else begin
            r_vga_r  <= w_stgl.vld ? w_qr : 2'd0;
            r_vga_g  <= w_stgl.vld ? w_qg : 2'd0;
            r_vga_b  <= w_stgl.vld ? w_qb : 2'd0;
            r_vga_hs <= w_stgl.hs;
            r_vga_vs <= w_stgl.vs;
        end
    end

    assign vga_r     = r_vga_r;
    assign vga_g     = r_vga_g;
    assign vga_b     = r_vga_b;
    assign vga_hsync = r_vga_hs;
    assign vga_vsync = r_vga_vs;

endmodule

// File: tb/tb_vga_scan_driver.sv
module tb_vga_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] s_px, s_py, f_px, f_py;
    logic       s_pv, s_fs, f_pv, f_fs;
    logic [7:0] s_rr, s_rg, s_rb, f_rr, f_rg, f_rb;
    logic [1:0] s_vr, s_vg, s_vb, f_vr, f_vg, f_vb;
    logic       s_hs, s_vs, f_hs, f_vs;

    vga_scan_driver #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .RT_LATENCY(1), .DITHER(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n),
        .pixel_x(s_px), .pixel_y(s_py), .pixel_valid(s_pv), .frame_start(s_fs),
        .rgb_r(s_rr), .rgb_g(s_rg), .rgb_b(s_rb),
        .vga_r(s_vr), .vga_g(s_vg), .vga_b(s_vb),
        .vga_hsync(s_hs), .vga_vsync(s_vs)
    );

    vga_scan_driver #(.RT_LATENCY(3), .DITHER(0)) u_full (
        .clk(clk), .rst_n(rst_n),
        .pixel_x(f_px), .pixel_y(f_py), .pixel_valid(f_pv), .frame_start(f_fs),
        .rgb_r(f_rr), .rgb_g(f_rg), .rgb_b(f_rb),
        .vga_r(f_vr), .vga_g(f_vg), .vga_b(f_vb),
        .vga_hsync(f_hs), .vga_vsync(f_vs)
    );

    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } chk_t;

    chk_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   epoch = 0;

    int cnt_v = 0, cnt_fs = 0, cnt_hs = 0, cnt_vs = 0, cnt_w = 0, cnt_k = 0;
    int fs1 = -1, fs2 = -1;

    function automatic logic [31:0] req(int x, int y, bit v, bit f);
        logic [9:0] xx, yy;
        xx = 10'(x);
        yy = 10'(y);
        return {10'd0, xx, yy, v, f};
    endfunction

    function automatic logic [31:0] pins(int r, int g, int b, bit hs, bit vs);
        logic [1:0] rr, gg, bb;
        rr = 2'(r);
        gg = 2'(g);
        bb = 2'(b);
        return {24'd0, rr, gg, bb, hs, vs};
    endfunction

    task automatic push(input int due, input int sel, input logic [31:0] e, input string nm);
        chk_t c;
        c.due = due;
        c.sel = sel;
        c.exp = e;
        c.nm  = nm;
        sb.push_back(c);
    endtask

    initial forever begin
        int si, fi;
        @(negedge clk);
        si = cyc - 2;
        fi = cyc - 4;
        if (si >= 650) begin
            s_rr = 8'hFF; s_rg = 8'hFF; s_rb = 8'hFF;
        end else begin
            s_rr = 8'h7F; s_rg = 8'hF0; s_rb = 8'h90;
        end
        f_rr = (fi < 0) ? 8'h00 : 8'((fi % 800) & 255);
        f_rg = 8'h00;
        f_rb = 8'h00;
    end

    initial forever begin
        @(negedge clk);
        if (epoch == 0 && rst_n) begin
            if (cyc >= 1 && cyc <= 650) begin
                cnt_v  += int'(s_pv);
                cnt_fs += int'(s_fs);
                if (s_fs) begin
                    if (fs1 < 0)      fs1 = cyc;
                    else if (fs2 < 0) fs2 = cyc;
                end
            end
            if (cyc >= 3 && cyc <= 652) begin
                cnt_hs += int'(!s_hs);
                cnt_vs += int'(!s_vs);
            end
            if (cyc >= 653 && cyc <= 977) begin
                if (s_vr == 2'd3 && s_vg == 2'd3 && s_vb == 2'd3) cnt_w++;
                if (s_vr == 2'd0 && s_vg == 2'd0 && s_vb == 2'd0) cnt_k++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [31:0] act;
                case (sb[i].sel)
                    0:       act = req(int'(s_px), int'(s_py), s_pv, s_fs);
                    1:       act = pins(int'(s_vr), int'(s_vg), int'(s_vb), s_hs, s_vs);
                    2:       act = req(int'(f_px), int'(f_py), f_pv, f_fs);
                    3:       act = pins(int'(f_vr), int'(f_vg), int'(f_vb), f_hs, f_vs);
                    4:       act = 32'(cnt_v);
                    5:       act = 32'(cnt_fs);
                    6:       act = 32'(cnt_hs);
                    7:       act = 32'(cnt_vs);
                    8:       act = 32'(fs2 - fs1);
                    9:       act = 32'(cnt_w);
                    default: act = 32'(cnt_k);
                endcase
                n_run++;
                if (act !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].nm, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        s_rr = 0; s_rg = 0; s_rb = 0; f_rr = 0; f_rg = 0; f_rb = 0;
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if (s_hs !== 1'b1) begin n_fail++; $display("FAIL async_rst_small_hs: got %b", s_hs); end
        n_run++;
        if (f_vs !== 1'b1) begin n_fail++; $display("FAIL async_rst_full_vs: got %b", f_vs); end
        n_run++;
        if (f_vr !== 2'd0) begin n_fail++; $display("FAIL async_rst_full_vr: got %h", f_vr); end
        push(0, 0, req(0, 0, 0, 0), "rst_small_req");
        push(0, 1, pins(0, 0, 0, 1, 1), "rst_small_pins");
        push(0, 2, req(0, 0, 0, 0), "rst_full_req");
        push(0, 3, pins(0, 0, 0, 1, 1), "rst_full_pins");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        push(1, 0, req(0, 0, 1, 1), "first_small_req");
        push(1, 2, req(0, 0, 1, 1), "first_full_req");
        push(16, 0, req(15, 0, 1, 0), "small_last_active");
        push(17, 0, req(16, 0, 0, 0), "small_first_blank");
        push(325, 0, req(24, 12, 0, 0), "small_frame_end");
        push(326, 0, req(0, 0, 1, 1), "small_wrap_fs");
        push(3, 1, pins(1, 3, 2, 1, 1), "dith_00");
        push(4, 1, pins(2, 3, 2, 1, 1), "dith_10");
        push(28, 1, pins(2, 3, 3, 1, 1), "dith_01");
        push(29, 1, pins(2, 3, 2, 1, 1), "dith_11");
        push(19, 1, pins(0, 0, 0, 1, 1), "blank_x16");
        push(21, 1, pins(0, 0, 0, 0, 1), "hsync_x18");
        push(228, 1, pins(0, 0, 0, 1, 0), "vsync_y9");
        push(655, 4, 32'd256, "cnt_valid_2fr");
        push(655, 5, 32'd2, "cnt_fs_2fr");
        push(655, 6, 32'd104, "cnt_hs_low");
        push(655, 7, 32'd100, "cnt_vs_low");
        push(655, 8, 32'd325, "fs_interval");
        push(980, 9, 32'd128, "cnt_white");
        push(980, 10, 32'd197, "cnt_black");
        push(193, 2, req(192, 0, 1, 0), "full_req_192");
        push(196, 3, pins(2, 0, 0, 1, 1), "full_r_191");
        push(197, 3, pins(3, 0, 0, 1, 1), "full_r_192");
        push(657, 2, req(656, 0, 0, 0), "full_req_656");
        push(660, 3, pins(0, 0, 0, 1, 1), "full_pre_hs");
        push(661, 3, pins(0, 0, 0, 0, 1), "full_hs_fall");
        push(1010, 1, pins(3, 3, 3, 1, 1), "pre_reset_white");

        while (cyc < 1010) @(negedge clk);
        @(posedge clk);
        #2;
        push(0, 0, req(0, 0, 0, 0), "mid_rst_small_req");
        push(0, 1, pins(0, 0, 0, 1, 1), "mid_rst_small_pins");
        push(0, 2, req(0, 0, 0, 0), "mid_rst_full_req");
        push(0, 3, pins(0, 0, 0, 1, 1), "mid_rst_full_pins");
        epoch = 1;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (s_pv !== 1'b0) begin n_fail++; $display("FAIL mid_async_small_pv: got %b", s_pv); end
        n_run++;
        if (s_vr !== 2'd0) begin n_fail++; $display("FAIL mid_async_small_vr: got %h", s_vr); end
        n_run++;
        if (f_fs !== 1'b0) begin n_fail++; $display("FAIL mid_async_full_fs: got %b", f_fs); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(1, 0, req(0, 0, 1, 1), "restart_small");
        push(2, 0, req(1, 0, 1, 0), "restart_small_x1");
        push(1, 2, req(0, 0, 1, 1), "restart_full");
        push(3, 1, pins(1, 3, 2, 1, 1), "restart_dith_00");
        repeat (6) @(negedge clk);
        #1;
        foreach (sb[i]) begin
            n_run++;
            n_fail++;
            $display("FAIL %s: never checked, due cyc %0d expected %h", sb[i].nm, sb[i].due, sb[i].exp);
        end
        if (n_run < 12) begin
            n_fail++;
            $display("FAIL too_few_checks: %0d", n_run);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Display-side counterpart of the raytracer datapath. Generates 640x480 VGA raster timing, issues `pixel_x`/`pixel_y`/`pixel_valid` requests to the raytracer core, and captures the returned 8-bit RGB after a fixed, parameterised latency. Quantises the RGB to 2 bits per channel with optional 2x2 ordered dither. Drives the 2-bit-per-channel VGA pins with sync signals aligned to the delayed colour.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porches and sync width
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porches and sync width
- `RT_LATENCY`, 1, cycles from a request (`pixel_valid`) to its valid `rgb_*`; legal range 0..15
- `DITHER`, 1, 1 = Bayer 2x2 dither, 0 = plain truncation

Ports:
- `clk`, in, 1, pixel clock
- `rst_n`, in, 1, asynchronous active-low reset
- `pixel_x`, out, 10, request column (raw horizontal count)
- `pixel_y`, out, 10, request row (raw vertical count)
- `pixel_valid`, out, 1, request is inside the active area
- `frame_start`, out, 1, one-cycle pulse with request (0,0)
- `rgb_r`, `rgb_g`, `rgb_b`, in, 8 each, raytracer colour, sampled `RT_LATENCY` cycles after the request
- `vga_r`, `vga_g`, `vga_b`, out, 2 each, quantised colour
- `vga_hsync`, `vga_vsync`, out, 1 each, active-low sync

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - `v_cnt` runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - `v_cnt` increments when `h_cnt` wraps; both wrap to 0 together at (799,524).
  - Both reset to 0 and free-run after reset; there is no stall input.
- Request stage (stage 0), registered from the counters every cycle:
  - `pixel_x<=h_cnt`, `pixel_y<=v_cnt`
  - `pixel_valid<=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)`
  - `frame_start<=(h_cnt==0)&&(v_cnt==0)`
  - Raw syncs computed in the same stage:
    - `hs_raw` is low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
    - `vs_raw` is low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment pipe:
  - A shift register `RT_LATENCY` deep carries {`pixel_valid`, `hs_raw`, `vs_raw`, `pixel_x[0]`, `pixel_y[0]`}.
  - Its output (stage L) is coincident with the `rgb_*` that answers the same request.
  - With `RT_LATENCY=0`, `rgb_*` is used in the same cycle as stage 0.
- Quantise, per channel c (8-bit), at stage L:
  - Dither offset d, indexed by (x0,y0): (0,0)=0, (1,0)=32, (0,1)=48, (1,1)=16. d=0 when `DITHER=0`.
  - s = c + d, 9-bit unsigned.
  - q = 3 if s >= 256, else s[7:6].
- Output stage (registered from stage L):
  - `vga_*` <= q when the delayed valid is 1, else 0.
  - `vga_hsync`/`vga_vsync` <= delayed raw syncs.
- `rgb_*` is ignored whenever the delayed valid is 0; blanking is always black.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - counters = 0
  - `pixel_x`=`pixel_y`=0, `pixel_valid`=0, `frame_start`=0
  - alignment pipe cleared, with syncs held at 1
  - `vga_r`/`vga_g`/`vga_b`=0, `vga_hsync`=`vga_vsync`=1
- First rising edge after reset release:
  - `pixel_x`=0, `pixel_y`=0, `pixel_valid`=1, `frame_start`=1
  - `h_cnt` becomes 1
- Request-to-pin latency:
  - A request shown in cycle k is on `vga_*` in cycle k+RT_LATENCY+1.
  - Syncs carry the identical delay, so the raster is shifted, not distorted.
- Per line: `pixel_valid` is high for 640 consecutive cycles, then low for 160.
- Per frame: 307200 valid cycles in 420000.
- `frame_start` pulses exactly once per 420000 cycles.
- Mid-frame reset: all outputs return immediately to their reset values. The raster restarts at (0,0) on the first edge after release, with no partial-line artifacts beyond the reset window.
- Wrap at (799,524): the next request is (0,0) with `frame_start`=1, with no idle cycle.

## Test plan
- Reset/start:
  - Stimulus: hold `rst_n`=0 for 5 cycles, then release.
  - Required: during reset, all outputs are at their reset values (syncs=1, colour=0).
  - Required: on the first edge after release, (x,y,valid,frame_start)=(0,0,1,1).
- Raster counts:
  - Stimulus: run 2 full frames.
  - Required: 420000 cycles between `frame_start` pulses, and 307200 `pixel_valid` cycles per frame.
  - Required: `vga_hsync` low for 96 cycles per line, `vga_vsync` low for 1600 cycles per frame.
- Latency alignment:
  - Stimulus: `RT_LATENCY`=3, `DITHER`=0; the model drives `rgb_r` = pixel_x[7:0] delayed by 3 cycles.
  - Required: request x=192 yields `vga_r`=3 four cycles later.
  - Required: hsync falls 4 cycles after the request with x=656.
- Dither:
  - Stimulus: `DITHER`=1, `rgb_r`=0x7F at (0,0), (1,0), (0,1), (1,1).
  - Required: `vga_r` = 1, 2, 2, 2 respectively.
  - Stimulus: `rgb_g`=0xF0 at (0,1).
  - Required: `vga_g`=3 (saturates).
- Blanking:
  - Stimulus: drive `rgb_*`=0xFF constantly.
  - Required: `vga_*`=0 for every output cycle whose delayed valid is 0, and 3 in the active area.
- Mid-frame reset:
  - Stimulus: assert `rst_n` at (300,200), hold for 3 cycles.
  - Required: outputs go to reset values immediately (asynchronously).
  - Required: restart at (0,0) with `frame_start`=1.
